alu_result_writeback: RTL and testbench

ALU_RESULT_WRITEBACK -- requirements
Module: alu_result_writeback

---
 rtl/alu_result_writeback.sv | 157 +++++++++++++++
 tb/tb_alu_result_writeback.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_writeback.sv
// alu_result_writeback: small circular queue between the ALU result bus and
// the register file write port. Results drain oldest-first, architectural
// flags are committed when an entry is written back, and queued results can
// be forwarded to the issue stage by destination register.
module alu_result_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ACT,
  input  logic [4:0]  DSTi,
  input  logic [63:0] R,
  input  logic [1:0]  SR,
  input  logic [15:0] COUT,
  input  logic        OVR,
  input  logic        Zero,
  input  logic        Sign,
  input  logic        WACK,
  output logic        WE,
  output logic [4:0]  WADDR,
  output logic [63:0] WDATA,
  output logic [7:0]  WBE,
  output logic [3:0]  FLAGS,
  output logic        FULL,
  output logic [3:0]  COUNT,
  output logic        ERR,
  input  logic [4:0]  RADDR,
  output logic        HIT,
  output logic [63:0] HDATA
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Payload storage; pointers and count define validity, so no reset needed.
  logic [4:0]  dst_mem  [DEPTH];
  logic [63:0] r_mem    [DEPTH];
  logic [1:0]  sr_mem   [DEPTH];
  logic [3:0]  flag_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    flags_reg, flags_next;
  logic          err_reg, err_next;

  logic          full_w;
  logic          pop_w;
  logic          push_w;
  logic [DEPTH-1:0] match_w;
  logic [PW-1:0] age_w [DEPTH];

  // Only the final nibble carry is architectural.
  logic unused_cout;
  assign unused_cout = ^COUT[14:0];

  assign full_w = (count_reg == FULL_CNT);
  assign WE     = (count_reg != '0);
  assign pop_w  = WE && WACK;
  // A full queue still takes a result when the head retires the same cycle.
  assign push_w = ACT && (!full_w || pop_w);

  assign FULL  = full_w;
  assign COUNT = 4'(count_reg);
  assign ERR   = err_reg;
  assign FLAGS = flags_reg;

  assign WADDR = dst_mem[rd_ptr_reg];
  assign WDATA = r_mem[rd_ptr_reg];

  // Byte enables cover the low 1/2/4/8 bytes of the result.
  always_comb begin
    WBE = 8'h00;
    case (sr_mem[rd_ptr_reg])
      2'd0:    WBE = 8'h01;
      2'd1:    WBE = 8'h03;
      2'd2:    WBE = 8'h0F;
      default: WBE = 8'hFF;
    endcase
  end

  // Per-entry age relative to the head; an entry is live when its age is
  // below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign age_w[gi]   = PW'(gi) - rd_ptr_reg;
    assign match_w[gi] = (CW'(age_w[gi]) < count_reg) && (dst_mem[gi] == RADDR);
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    HIT   = 1'b0;
    HDATA = 64'h0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PW'(k);
      if (match_w[idx]) begin
        HIT   = 1'b1;
        HDATA = r_mem[idx];
      end
    end
  end

  // Next-state for pointers, occupancy, committed flags and sticky error.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    flags_next  = flags_reg;
    err_next    = err_reg;
    if (push_w) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop_w) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      flags_next  = flag_mem[rd_ptr_reg];
    end
    if (push_w && !pop_w) begin
      count_next = count_reg + 1'b1;
    end else if (pop_w && !push_w) begin
      count_next = count_reg - 1'b1;
    end
    if (ACT && !push_w) begin
      err_next = 1'b1;
    end
  end

  // Control state register; reset discards all pending entries.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      flags_reg  <= 4'h0;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      flags_reg  <= flags_next;
      err_reg    <= err_next;
    end
  end

  // Payload write at the tail; becomes visible at the head next cycle at the earliest.
  always_ff @(posedge CLK) begin
    if (push_w && !RESET) begin
      dst_mem[wr_ptr_reg]  <= DSTi;
      r_mem[wr_ptr_reg]    <= R;
      sr_mem[wr_ptr_reg]   <= SR;
      flag_mem[wr_ptr_reg] <= {COUT[15], OVR, Zero, Sign};
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the writeback buffer.
module tb_alu_result_writeback;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET, ACT, OVR, Zero, Sign, WACK;
  logic [4:0]  DSTi, RADDR, WADDR;
  logic [63:0] R, WDATA, HDATA;
  logic [1:0]  SR;
  logic [15:0] COUT;
  logic        WE, FULL, ERR, HIT;
  logic [7:0]  WBE;
  logic [3:0]  FLAGS, COUNT;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] r;
    logic [1:0]  sr;
    logic [3:0]  f;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_flags;
  logic       m_err;

  alu_result_writeback #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .DSTi(DSTi), .R(R), .SR(SR),
    .COUT(COUT), .OVR(OVR), .Zero(Zero), .Sign(Sign), .WACK(WACK),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .WBE(WBE), .FLAGS(FLAGS),
    .FULL(FULL), .COUNT(COUNT), .ERR(ERR), .RADDR(RADDR), .HIT(HIT),
    .HDATA(HDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, then advance model and DUT one edge.
  task automatic cyc();
    ent_t e;
    int   sz;
    logic exp_hit;
    logic [63:0] exp_hdata;
    logic pop, push;
    #1;
    chk("WE", 64'(WE), 64'(q.size() != 0));
    chk("COUNT", 64'(COUNT), 64'(q.size()));
    chk("FULL", 64'(FULL), 64'(q.size() == DEPTH));
    chk("ERR", 64'(ERR), 64'(m_err));
    chk("FLAGS", 64'(FLAGS), 64'(m_flags));
    if (q.size() != 0) begin
      sz = 1 << q[0].sr;
      chk("WADDR", 64'(WADDR), 64'(q[0].dst));
      chk("WDATA", WDATA, q[0].r);
      chk("WBE", 64'(WBE), 64'((1 << sz) - 1));
    end
    exp_hit = 1'b0;
    exp_hdata = 64'h0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].dst == RADDR) begin
        exp_hit = 1'b1;
        exp_hdata = q[i].r;
        break;
      end
    end
    chk("HIT", 64'(HIT), 64'(exp_hit));
    chk("HDATA", HDATA, exp_hdata);
    if (RESET) begin
      q.delete();
      m_flags = 4'h0;
      m_err = 1'b0;
    end else begin
      pop  = (q.size() != 0) && WACK;
      push = ACT && ((q.size() < DEPTH) || pop);
      if (ACT && !push) m_err = 1'b1;
      if (pop) begin
        m_flags = q[0].f;
        void'(q.pop_front());
      end
      if (push) begin
        e.dst = DSTi; e.r = R; e.sr = SR; e.f = {COUT[15], OVR, Zero, Sign};
        q.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic a, input logic [4:0] d, input logic [63:0] rv,
                       input logic [1:0] s, input logic [3:0] f, input logic w);
    ACT = a; DSTi = d; R = rv; SR = s; WACK = w;
    COUT = {f[3], 15'($urandom)};
    OVR = f[2]; Zero = f[1]; Sign = f[0];
    cyc();
  endtask

  initial begin
    RESET = 1'b1; ACT = 0; DSTi = 0; R = 0; SR = 0; COUT = 0;
    OVR = 0; Zero = 0; Sign = 0; WACK = 0; RADDR = 0;
    m_flags = 4'h0; m_err = 1'b0;
    @(posedge CLK); #1;
    cyc();
    RESET = 1'b0;
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);

    // Single push, committed next cycle.
    RADDR = 5'd5;
    drive(1, 5'd5, 64'h1122334455667788, 2'd1, 4'b1001, 1);
    chk("sp_we", 64'(WE), 64'd1);
    chk("sp_waddr", 64'(WADDR), 64'd5);
    chk("sp_wbe", 64'(WBE), 64'h03);
    chk("sp_wdata", WDATA, 64'h1122334455667788);
    drive(0, 5'd0, 64'h0, 2'd0, 4'h0, 1);
    chk("sp_flags", 64'(FLAGS), 64'b1001);
    chk("sp_count", 64'(COUNT), 64'd0);

    // Fill and overflow with writes stalled.
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(10 + i), {$urandom, $urandom}, 2'(i), 4'(i), 0);
      if (i == 3) chk("fill_full", 64'(FULL), 64'd1);
    end
    chk("ovf_err", 64'(ERR), 64'd1);
    chk("ovf_count", 64'(COUNT), 64'd4);
    for (int i = 0; i < 5; i++) drive(0, 5'd0, 64'h0, 2'd0, 4'h0, 1);

    // Full queue with simultaneous push and pop.
    RESET = 1'b1; cyc(); RESET = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 5'(i), {$urandom, $urandom}, 2'd3, 4'hF, 0);
    drive(1, 5'd20, 64'hDEAD, 2'd2, 4'h6, 1);
    chk("fpp_count", 64'(COUNT), 64'd4);
    chk("fpp_err", 64'(ERR), 64'd0);
    for (int i = 0; i < 5; i++) drive(0, 5'd0, 64'h0, 2'd0, 4'h0, 1);

    // Wrap-around with back-to-back push/pop pairs.
    for (int i = 0; i < 10; i++) drive(1, 5'(i), {$urandom, $urandom}, 2'($urandom), 4'($urandom), 1);
    drive(0, 5'd0, 64'h0, 2'd0, 4'h0, 1);

    // Forwarding picks the youngest of two matches.
    drive(1, 5'd3, 64'hA, 2'd3, 4'h0, 0);
    drive(1, 5'd3, 64'hB, 2'd3, 4'h0, 0);
    RADDR = 5'd3; #1;
    chk("fwd_hit", 64'(HIT), 64'd1);
    chk("fwd_hdata", HDATA, 64'hB);
    RADDR = 5'd4; #1;
    chk("fwd_miss_hit", 64'(HIT), 64'd0);
    chk("fwd_miss_hdata", HDATA, 64'h0);
    drive(0, 5'd0, 64'h0, 2'd0, 4'h0, 0);

    // Reset mid-drain.
    drive(1, 5'd7, 64'h77, 2'd0, 4'h0, 0);
    chk("rmd_count3", 64'(COUNT), 64'd3);
    RESET = 1'b1; WACK = 1'b1; cyc(); RESET = 1'b0;
    chk("rmd_count", 64'(COUNT), 64'd0);
    chk("rmd_we", 64'(WE), 64'd0);
    chk("rmd_flags", 64'(FLAGS), 64'd0);
    chk("rmd_err", 64'(ERR), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      RADDR = 5'($urandom_range(0, 7));
      RESET = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            2'($urandom), 4'($urandom), $urandom_range(0, 2) == 0);
    end
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
